// File: rtl/me_host_seq.sv
// me_host_seq: streams a K*N-bit operand to the mod-exp core and reassembles its N-word result
module me_host_seq #(
  parameter int unsigned K         = 128,
  parameter int unsigned N         = 16,
  parameter int unsigned START_GAP = 10,
  parameter int unsigned PAD_WORDS = 1,
  parameter int unsigned TIMEOUT   = 1048576
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_start,
  input  logic [K*N-1:0] req_x,
  output logic           busy,
  output logic           me_start,
  output logic [K-1:0]   me_x,
  output logic           me_x_valid,
  input  logic [K-1:0]   me_result,
  input  logic           me_valid,
  output logic [K*N-1:0] rsp_result,
  output logic           rsp_valid,
  output logic           rsp_timeout
);
  localparam int CW = $clog2(N + PAD_WORDS + 1);
  localparam int GW = (START_GAP == 0) ? 1 : $clog2(START_GAP + 1);
  localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, START, GAP, SEND, WAIT, RECV, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [K*N-1:0] op_q, op_d, cap_q, cap_d, rsp_result_q, rsp_result_d;
  logic [K-1:0] me_x_q, me_x_d;
  logic busy_q, busy_d, me_start_q, me_start_d, me_x_valid_q, me_x_valid_d;
  logic rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d, emit;
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gcnt_d        = gcnt_q;
    tcnt_d        = tcnt_q;
    op_d          = op_q;
    cap_d         = cap_q;
    rsp_result_d  = rsp_result_q;
    me_start_d    = 1'b0;
    me_x_d        = '0;
    me_x_valid_d  = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    // cnt_q indexes the next operand word; it is zeroed on acceptance so the gap needs no reload
    emit = (state_q == START && START_GAP == 0) ||
           (state_q == GAP && 32'(gcnt_q) + 1 == START_GAP) ||
           (state_q == SEND && 32'(cnt_q) != N + PAD_WORDS);
    if (emit) begin
      state_d      = SEND;
      me_x_valid_d = 1'b1;
      me_x_d       = (32'(cnt_q) < N) ? op_q[32'(cnt_q)*K +: K] : '0;
      cnt_d        = cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: if (req_start) begin
        state_d    = START;
        op_d       = req_x;
        cnt_d      = '0;
        me_start_d = 1'b1;
      end
      START: if (!emit) begin
        state_d = GAP;
        gcnt_d  = '0;
      end
      GAP: if (!emit) gcnt_d = gcnt_q + 1'b1;
      SEND: if (!emit) begin
        state_d = WAIT;
        cnt_d   = '0;
        tcnt_d  = '0;
      end
      WAIT, RECV: begin
        tcnt_d = tcnt_q + 1'b1;
        if (me_valid) begin
          cap_d[32'(cnt_q)*K +: K] = me_result;
          cnt_d   = cnt_q + 1'b1;
          state_d = RECV;
        end
        if (me_valid && 32'(cnt_q) == N - 1) begin
          state_d      = DONE;
          rsp_result_d = cap_d;
          rsp_valid_d  = 1'b1;
        end else if (TIMEOUT != 0 && 32'(tcnt_q) + 1 == TIMEOUT) begin
          state_d       = IDLE;
          rsp_timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      gcnt_q        <= '0;
      tcnt_q        <= '0;
      op_q          <= '0;
      cap_q         <= '0;
      rsp_result_q  <= '0;
      busy_q        <= 1'b0;
      me_start_q    <= 1'b0;
      me_x_q        <= '0;
      me_x_valid_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gcnt_q        <= gcnt_d;
      tcnt_q        <= tcnt_d;
      op_q          <= op_d;
      cap_q         <= cap_d;
      rsp_result_q  <= rsp_result_d;
      busy_q        <= busy_d;
      me_start_q    <= me_start_d;
      me_x_q        <= me_x_d;
      me_x_valid_q  <= me_x_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign busy        = busy_q;
  assign me_start    = me_start_q;
  assign me_x        = me_x_q;
  assign me_x_valid  = me_x_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_me_host_seq.sv
// tb_me_host_seq: timeline model of the host sequencer plus directed operations
module tb_me_host_seq;
  localparam int K = 128, N = 16, G = 10, P = 1, TO = 100, W = K * N;
  localparam int SE = 1 + G + N + P;
  logic clk = 0, rst = 1, req_start = 0, me_valid = 0;
  logic [W-1:0] req_x = '0;
  logic [K-1:0] me_result = '0;
  logic busy, me_start, me_x_valid, rsp_valid, rsp_timeout;
  logic [K-1:0] me_x;
  logic [W-1:0] rsp_result;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  me_host_seq #(.K(K), .N(N), .START_GAP(G), .PAD_WORDS(P), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_x(req_x), .busy(busy),
    .me_start(me_start), .me_x(me_x), .me_x_valid(me_x_valid), .me_result(me_result),
    .me_valid(me_valid), .rsp_result(rsp_result), .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout)
  );
  always #5 clk = ~clk;
  task automatic lit(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  // Model: phases follow from the number of edges since the accepted request
  int cyc = 0, t0 = 0, k, j, nrx;
  bit m_active = 0, m_done = 0;
  logic [W-1:0] m_op = '0, m_acc = '0, e_rr = '0;
  logic [K-1:0] e_x = '0;
  logic e_busy = 0, e_start = 0, e_xv = 0, e_rv = 0, e_to = 0;
  always @(posedge clk) begin
    e_start = 0; e_xv = 0; e_x = '0; e_rv = 0; e_to = 0;
    if (rst) begin
      m_active = 0; m_done = 0; e_busy = 0; e_rr = '0;
    end else if (m_done) begin
      m_done = 0; m_active = 0; e_busy = 0;
    end else if (!m_active) begin
      if (req_start) begin
        m_active = 1; t0 = cyc; m_op = req_x; nrx = 0; e_start = 1; e_busy = 1;
      end
    end else begin
      k = cyc - t0;
      if (k >= 1 + G && k < SE) begin
        j = k - 1 - G;
        e_xv = 1;
        e_x = (j < N) ? m_op[K*j +: K] : '0;
      end else if (k > SE) begin
        if (me_valid) begin
          m_acc[K*nrx +: K] = me_result;
          nrx++;
        end
        if (me_valid && nrx == N) begin
          e_rr = m_acc; e_rv = 1; m_done = 1;
        end else if (k - SE == TO) begin
          e_to = 1; m_active = 0; e_busy = 0;
        end
      end
    end
    cyc++;
  end
  always @(negedge clk) if (chk_en) begin
    lit("busy", busy, e_busy);
    lit("me_start", me_start, e_start);
    lit("me_x_valid", me_x_valid, e_xv);
    lit("me_x", me_x, e_x);
    lit("rsp_valid", rsp_valid, e_rv);
    lit("rsp_timeout", rsp_timeout, e_to);
    n_cmp++;
    if (rsp_result !== e_rr) begin
      n_bad++;
      for (int i = 0; i < N; i++)
        if (rsp_result[K*i +: K] !== e_rr[K*i +: K]) begin
          $display("FAIL rsp_result word %0d: got %0h, expected %0h", i, rsp_result[K*i +: K], e_rr[K*i +: K]);
          break;
        end
    end
  end
  task automatic run_op(input int ob, input int rb, input bit gap_rx, input bit spur, input bit hold, input int nw);
    int n, w;
    @(negedge clk);
    for (int i = 0; i < N; i++) req_x[K*i +: K] = 128'(ob + i + 1);
    req_start = 1;
    @(negedge clk);
    lit("me_start_pulse", me_start, 1);
    if (!hold) req_start = 0;
    @(negedge clk);
    lit("me_start_low", me_start, 0);
    n = 0;
    while (!me_x_valid && n < 50) begin
      me_valid = spur; me_result = '1;
      @(negedge clk); n++;
    end
    w = 0;
    while (me_x_valid && w < 50) begin
      if (w == 0) lit("first_word", me_x, 128'(ob + 1));
      if (w == N - 1) lit("last_word", me_x, 128'(ob + N));
      if (w == N) lit("pad_word", me_x, 0);
      me_valid = spur; me_result = '1;
      @(negedge clk); w++;
    end
    me_valid = 0;
    lit("xv_len", 128'(w), 128'(N + P));
    if (nw == 0) begin
      n = 0;
      while (!rsp_timeout && n < 200) begin @(negedge clk); n++; end
      lit("timeout_cycles", 128'(n), 128'(TO));
      return;
    end
    repeat (50) @(negedge clk);
    for (int i = 0; i < nw; i++) begin
      if (gap_rx && i > 0) begin me_valid = 0; @(negedge clk); end
      me_valid = 1; me_result = 128'(rb + i);
      @(negedge clk);
    end
    me_valid = 0;
    if (nw == N) begin
      lit("rsp_valid_hi", rsp_valid, 1);
      lit("busy_in_done", busy, 1);
      @(negedge clk);
      if (hold) req_start = 0;
      lit("rsp_valid_lo", rsp_valid, 0);
      lit("busy_after", busy, 0);
    end else begin
      rst = 1;
      @(negedge clk);
      lit("rst_busy", busy, 0);
      lit("rst_result", rsp_result[K-1:0], 0);
      rst = 0;
      @(negedge clk);
    end
  endtask
  initial begin
    req_start = 1;
    repeat (3) @(negedge clk);
    chk_en = 1;
    lit("rst_me_start", me_start, 0);
    req_start = 0;
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    lit("idle_busy", busy, 0);
    run_op(0, 'hA0, 0, 0, 0, N);
    lit("res_w0", rsp_result[0 +: K], 'hA0);
    lit("res_w7", rsp_result[K*7 +: K], 'hA7);
    lit("res_w15", rsp_result[K*15 +: K], 'hAF);
    run_op(100, 'hA0, 1, 1, 0, N);
    lit("gap_w3", rsp_result[K*3 +: K], 'hA3);
    run_op(200, 'hC0, 0, 0, 1, N);
    lit("hold_w1", rsp_result[K +: K], 'hC1);
    run_op(300, 'hE0, 0, 0, 0, N);
    lit("second_w0", rsp_result[0 +: K], 'hE0);
    run_op(400, 0, 0, 0, 0, 0);
    lit("timeout_keep", rsp_result[K*15 +: K], 'hEF);
    run_op(500, 'h10, 0, 0, 0, 5);
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/me_host_seq.md
Name: me_host_seq

Overview:
- Host-side sequencer that drives the modular-exponentiation core's streaming interface and collects its result.
- Accepts a K*N-bit operand in parallel and pulses me_start.
- Streams the operand as K-bit words, least-significant word first, on me_x/me_x_valid.
- Deserialises the N-word me_result stream back into a K*N-bit register and reports completion or timeout.

Parameters:
- K, 128, word width in bits.
- N, 16, words per operand/result (2048-bit default).
- START_GAP, 10, idle cycles between the me_start pulse and the first me_x_valid.
- PAD_WORDS, 1, zero words appended after the N operand words, with me_x_valid high.
- TIMEOUT, 1048576, max cycles spent in WAIT+RECV before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- req_start  in  1  start request; sampled only in IDLE.
- req_x  in  K*N  operand; latched on the accepted req_start.
- busy  out  1  high in every state except IDLE.
- me_start  out  1  one-cycle start pulse to the core.
- me_x  out  K  operand word to the core.
- me_x_valid  out  1  me_x qualifier.
- me_result  in  K  result word from the core.
- me_valid  in  1  me_result qualifier.
- rsp_result  out  K*N  assembled result; held until the next completion.
- rsp_valid  out  1  one-cycle pulse when rsp_result is updated.
- rsp_timeout  out  1  one-cycle pulse on abort.

Behaviour:
- Reset: state IDLE; all counters 0; busy, me_start, me_x, me_x_valid, rsp_result, rsp_valid and rsp_timeout are 0. Reset in any state aborts immediately with no rsp pulse.
- All outputs are registered.
- IDLE: when req_start=1 at edge t, latch req_x and go to START. req_start in any other state is ignored.
- START: me_start=1 for exactly the cycle after t. Next state is GAP, or SEND if START_GAP=0.
- GAP: START_GAP cycles with me_start=0 and me_x_valid=0. The first me_x_valid cycle is t+2+START_GAP.
- SEND: N+PAD_WORDS consecutive cycles with me_x_valid=1.
  - Word i (0..N-1) is operand[K*i +: K].
  - Pad words are 0.
  - No backpressure; the stream never stalls.
  - On the cycle after the last word, me_x=0 and me_x_valid=0; go to WAIT.
- WAIT: on the first me_valid=1 cycle, capture that word as index 0 and go to RECV with the count at 1.
- RECV: each me_valid=1 cycle captures me_result as word index cnt, then cnt increments.
  - me_valid=0 cycles are gaps: no capture, no count.
  - When word N-1 is captured, go to DONE.
- DONE: rsp_result updated with all N words, least-significant word = first received; rsp_valid=1 for one cycle; then IDLE.
  - req_start may be accepted on the cycle rsp_valid is high? No: in DONE the state is not IDLE, so it is ignored. It is accepted from the next cycle.
- me_valid in IDLE, START, GAP or SEND is ignored and never captured.
- Timeout: a counter is cleared on entry to WAIT and increments each cycle in WAIT/RECV. When it reaches TIMEOUT (TIMEOUT≠0): rsp_timeout=1 for one cycle, rsp_result unchanged, state IDLE.
- The partial-capture buffer is separate from rsp_result. rsp_result changes only in DONE.
- Counter widths: clog2(N+PAD_WORDS+1), clog2(START_GAP+1) and clog2(TIMEOUT+1), minimum 1 bit each. No wrap is reachable.
- Latency from req_start to rsp_valid = 2 + START_GAP + N + PAD_WORDS + (core latency) + N + 1, with me_valid assumed contiguous.

Test Plan:
1. Reset then idle: all outputs 0 for 20 cycles. req_start pulsed with rst=1 -> no me_start.
2. Basic stream: K=128, N=16, START_GAP=10, req_x word i = 128'h(i+1), req_start at t.
   - me_start high only at t+1.
   - me_x_valid high t+12..t+28.
   - me_x = 1..16 then 0.
3. Loopback responder: returns words 0xA0+i on 16 contiguous me_valid cycles 50 cycles after SEND ends.
   - rsp_result[128*i +: 128] = 0xA0+i.
   - rsp_valid exactly one cycle, one cycle after the last word.
   - busy falls with it.
4. Gapped result: me_valid toggles 1,0,1,0… for 16 valid words -> same assembled result; spurious me_valid during GAP/SEND is ignored and the result is unaffected.
5. req_start re-asserted while busy and on the rsp_valid cycle -> ignored. A second operation started afterwards completes independently, and rsp_result holds its old value until then.
6. Timeout: TIMEOUT=100, responder silent -> rsp_timeout pulses 100 cycles after entering WAIT, rsp_valid never pulses, rsp_result unchanged. Also: rst asserted mid-RECV -> immediate IDLE, outputs 0.
